display_scan_arbiter: RTL and testbench
=======================================

# display_scan_arbiter

Time-multiplexed scan controller and two-requester arbiter for the 4-digit 7-segment display. Two sources each present a 16-bit BCD word (4 nibbles) and request ownership of the display; the block grants one at a time with a minimum hold, snapshots the owner's word at frame boundaries, and sequences anode scanning. It emits one BCD nibble per digit slot to the downstream BCD-to-7-segment decoder. It replaces free-running anode rotation, letting a second datapath (e.g. a counter or status word) share the display with the adder result.

## Interface
- `SCAN_DIV`, 25000: `clk` cycles per digit slot; minimum 2.
- `HOLD_FRAMES`, 256: minimum full frames an owner keeps the display before preemption; minimum 1.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst`  in  1: reset; one clock; synchronous, active-high.
- `req`  in  2: `req[i]` = source i wants the display; level-sensitive.
- `data0`  in  16: source 0 BCD word; `[15:12]` is the most significant digit.
- `data1`  in  16: source 1 BCD word.
- `grant`  out  2: one-hot ownership, or `00` when idle; registered.
- `an`  out  4: anodes, active-low; `an[k]` low = digit k lit.
- `digit`  out  4: BCD nibble for the currently lit digit slot; registered.
- `frame`  out  1: one-cycle pulse on each frame boundary.

## Operation
- Prescaler `pc` counts 0..`SCAN_DIV`-1 and wraps. `tick` = (`pc`==`SCAN_DIV`-1).
- Digit index `idx` advances 0→1→2→3→0 on each tick.
- Frame boundary `fb` = `tick` && `idx`==3. The `frame` output is `fb` registered.
- FSM states `IDLE`, `OWN0`, `OWN1`. All transitions are evaluated only on `fb`:
  - `IDLE`:
    - Exactly one `req` set: go to that owner.
    - Both set: grant the source that is not `last`. `last` is the most recent owner; reset value 1, so source 0 wins the first tie.
  - `OWNi`, own req dropped:
    - Other source requesting: go to `OWNj`.
    - Otherwise: go to `IDLE`.
  - `OWNi`, own req held:
    - Other source requesting and `hold_cnt` ≥ `HOLD_FRAMES`: preempt, go to `OWNj`.
    - Otherwise: stay.
- `hold_cnt` behaviour:
  - Cleared on any change of state.
  - Incremented on each `fb` while owning.
  - Saturates at `HOLD_FRAMES`.
- Shadow register `shw[15:0]`:
  - Loaded on every `fb` from the data word of the next-state owner.
  - Never changes mid-frame, so the display does not tear.
  - Loaded with 0 when the next state is `IDLE`.
- Leading-zero blanking, from `shw`:
  - Digit k (k=3..1) is blank if its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked while owned.
- Outputs:
  - `an` = `~(4'b0001<<idx)` unless idle or the digit is blank; then `4'b1111`.
  - `digit` = `shw[4*idx+:4]`.
- Non-BCD nibbles (A–F) pass through unmodified.

## Timing
- Reset values:
  - `an`=`4'b1111`, `digit`=0, `grant`=00, `frame`=0.
  - `pc`=0, `idx`=0, `hold_cnt`=0, `shw`=0, state `IDLE`, `last`=1.
- `rst` mid-frame: all of the above on the next edge. An in-progress grant is dropped with no completion frame.
- Frame length is 4·`SCAN_DIV` cycles.
- Request-to-grant latency is at most 4·`SCAN_DIV` cycles. `grant` and `shw` update on the same edge as the `fb` cycle.
- `an`/`digit` are registered, one cycle after `idx`/`shw`. The first slot of a new owner shows digit 0 one cycle after the grant edge.
- `req` pulses that rise and fall between boundaries are ignored.
- Owner drops `req` while the other is absent and within hold: release to `IDLE` at the next `fb`. Hold blocks preemption only, never release.
- In `IDLE`, `pc`/`idx` keep running so that frame boundaries stay periodic.

## Structure
- Package `display_pkg`:
  - State enum (`IDLE`/`OWN0`/`OWN1`).
  - `AN_OFF`=`4'b1111`.
  - Digit-count constant 4.
- Sub-module `scan_timer`:
  - Contains the prescaler and `idx`.
  - Parameter `SCAN_DIV`.
  - Outputs `tick`, `idx[1:0]`, `fb`.
- Arbiter FSM, shadow register and blanking stay in the top module.

## Test plan
Bench uses `SCAN_DIV`=4 and `HOLD_FRAMES`=2, giving a 16-cycle frame.

- Reset check: hold `rst` 3 cycles → `an`=1111, `grant`=00, `frame`=0. After release, the first `frame` pulse arrives 16 cycles later.
- Single request: `req`=01, `data0`=16'h0042 → `grant`=01 at the next `fb`. Slots show `digit` 2 with `an`=1110, then 4 with `an`=1101. Slots 2 and 3 stay dark (`an`=1111).
- Tie with round-robin:
  - `req`=11 from `IDLE` after reset → `grant`=01.
  - Drop both, return to `IDLE`, raise `req`=11 again → `grant`=10.
- Hold and preemption: owner 0 holds `req`, raise `req[1]` at frame 0 of ownership → `grant` stays 01 for 2 frames, then switches to 10 at the third `fb`.
- Snapshot: change `data0` from 16'h1234 to 16'h5678 mid-frame → remaining slots of that frame show 1234. The next frame shows 5678.
- Mid-operation reset: assert `rst` during `OWN1` at `idx`=2 → next cycle `an`=1111, `grant`=00. Re-request gives normal grant latency.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit display scan arbiter.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0]  AN_OFF     = 4'b1111;
    localparam int unsigned NUM_DIGITS = 4;

    // Digit k is blank when it and every higher nibble are zero; digit 0 always shows.
    function automatic logic digit_blank(input logic [15:0] shw, input logic [1:0] idx);
        case (idx)
            2'd3:    return shw[15:12] == 4'h0;
            2'd2:    return shw[15:8] == 8'h00;
            2'd1:    return shw[15:4] == 12'h000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot prescaler and digit index; flags the last slot of each frame.
module scan_timer
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 25000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [1:0] idx,
    output logic       fb
);

    localparam int unsigned     PC_W     = $clog2(SCAN_DIV);
    localparam logic [PC_W-1:0] PC_MAX   = PC_W'(SCAN_DIV - 1);
    localparam logic [1:0]      LAST_IDX = 2'(NUM_DIGITS - 1);

    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= '0;
            r_idx <= 2'd0;
        end else if (tick) begin
            r_pc  <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign tick = (r_pc == PC_MAX);
    assign idx  = r_idx;
    assign fb   = tick && (r_idx == LAST_IDX);

endmodule

// File: rtl/display_scan_arbiter.sv
// Two-source display arbiter with minimum hold, frame-aligned snapshot and anode scanning.
module display_scan_arbiter
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 25000,
    parameter int unsigned HOLD_FRAMES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  grant,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        frame
);

    localparam int unsigned     HC_W     = $clog2(HOLD_FRAMES + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_FRAMES);

    logic            w_tick;
    logic [1:0]      w_idx;
    logic            w_fb;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last;
    logic [HC_W-1:0] r_hold_cnt;
    logic [15:0]     r_shw;
    logic [15:0]     w_next_shw;
    logic [1:0]      w_next_grant;
    logic [1:0]      r_grant;
    logic [3:0]      r_an;
    logic [3:0]      r_digit;
    logic            r_frame;
    logic            r_tick_d;
    logic [3:0]      w_an_next;
    logic [3:0]      w_digit_next;

    scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick),
        .idx  (w_idx),
        .fb   (w_fb)
    );

    always_comb begin
        w_next_state = r_state;
        if (w_fb) begin
            unique case (r_state)
                IDLE: begin
                    if (req == 2'b01)      w_next_state = OWN0;
                    else if (req == 2'b10) w_next_state = OWN1;
                    else if (req == 2'b11) w_next_state = r_last ? OWN0 : OWN1;
                end
                OWN0: begin
                    if (!req[0])                             w_next_state = req[1] ? OWN1 : IDLE;
                    else if (req[1] && r_hold_cnt >= HOLD_MAX) w_next_state = OWN1;
                end
                OWN1: begin
                    if (!req[1])                             w_next_state = req[0] ? OWN0 : IDLE;
                    else if (req[0] && r_hold_cnt >= HOLD_MAX) w_next_state = OWN0;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_next_shw   = 16'h0000;
        w_next_grant = 2'b00;
        case (w_next_state)
            OWN0: begin
                w_next_shw   = data0;
                w_next_grant = 2'b01;
            end
            OWN1: begin
                w_next_shw   = data1;
                w_next_grant = 2'b10;
            end
            default: ;
        endcase
    end

    assign w_an_next    = (r_state == IDLE || digit_blank(r_shw, w_idx)) ? AN_OFF
                                                                         : ~(4'b0001 << w_idx);
    assign w_digit_next = r_shw[{w_idx, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
            r_shw      <= 16'h0000;
            r_grant    <= 2'b00;
            r_an       <= AN_OFF;
            r_digit    <= 4'h0;
            r_frame    <= 1'b0;
            r_tick_d   <= 1'b0;
        end else begin
            r_frame  <= w_fb;
            r_tick_d <= w_tick;
            if (w_fb) begin
                r_state <= w_next_state;
                r_grant <= w_next_grant;
                r_shw   <= w_next_shw;
                if (w_next_state != r_state) begin
                    r_hold_cnt <= '0;
                end else if (r_state != IDLE && r_hold_cnt != HOLD_MAX) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
                if (w_next_state == OWN0) r_last <= 1'b0;
                if (w_next_state == OWN1) r_last <= 1'b1;
            end
            // idx and shw only move on a tick, so refreshing the outputs right after one suffices
            if (r_tick_d) begin
                r_an    <= w_an_next;
                r_digit <= w_digit_next;
            end
        end
    end

    assign grant = r_grant;
    assign an    = r_an;
    assign digit = r_digit;
    assign frame = r_frame;

endmodule

// File: tb/tb_display_scan_arbiter.sv
// Randomized and directed bench for display_scan_arbiter against a frame-level reference model.
module tb_display_scan_arbiter;

    localparam int SD = 4;
    localparam int HF = 2;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] data0 = 16'h0000;
    logic [15:0] data1 = 16'h0000;
    logic [1:0]  grant;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        frame;

    always #5 clk = ~clk;

    display_scan_arbiter #(
        .SCAN_DIV    (SD),
        .HOLD_FRAMES (HF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .grant (grant),
        .an    (an),
        .digit (digit),
        .frame (frame)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner is -1 (none), 0 or 1; time is edges since reset.
    int          m_cyc  = 0;
    int          m_own  = -1;
    int          m_last = 1;
    int          m_hold = 0;
    logic [15:0] m_shw  = 16'h0000;
    logic [3:0]  m_an   = 4'hF;
    logic [3:0]  m_digit = 4'h0;
    logic        m_frame = 1'b0;
    logic [1:0]  m_grant = 2'b00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int          idx;
        bit          fb;
        int          other;
        int          nxt;
        logic [15:0] sh;
        logic [3:0]  one;
        if (rst) begin
            m_cyc = 0; m_own = -1; m_last = 1; m_hold = 0; m_shw = 16'h0000;
            m_an = 4'hF; m_digit = 4'h0; m_frame = 1'b0; m_grant = 2'b00;
            return;
        end
        idx = (m_cyc / SD) % 4;
        fb  = (m_cyc % FR) == FR - 1;
        sh  = m_shw >> (4 * idx);
        one = 4'b0001;
        m_digit = sh[3:0];
        if (m_own < 0 || (idx > 0 && sh == 16'h0000)) m_an = 4'hF;
        else m_an = ~(one << idx);
        m_frame = fb;
        if (fb) begin
            nxt = m_own;
            if (m_own < 0) begin
                if (req == 2'b01)      nxt = 0;
                else if (req == 2'b10) nxt = 1;
                else if (req == 2'b11) nxt = 1 - m_last;
            end else begin
                other = 1 - m_own;
                if (!req[m_own])                    nxt = req[other] ? other : -1;
                else if (req[other] && m_hold >= HF) nxt = other;
            end
            if (nxt != m_own)              m_hold = 0;
            else if (nxt >= 0 && m_hold < HF) m_hold++;
            m_own = nxt;
            if (nxt >= 0) m_last = nxt;
            m_shw   = (nxt < 0) ? 16'h0000 : ((nxt == 0) ? data0 : data1);
            m_grant = (nxt < 0) ? 2'b00 : ((nxt == 0) ? 2'b01 : 2'b10);
        end
        m_cyc++;
    endtask

    task automatic cyc();
        model_edge();
        @(negedge clk);
        check_eq("an", {28'd0, an}, {28'd0, m_an});
        check_eq("digit", {28'd0, digit}, {28'd0, m_digit});
        check_eq("grant", {30'd0, grant}, {30'd0, m_grant});
        check_eq("frame", {31'd0, frame}, {31'd0, m_frame});
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input logic [1:0] g, input int maxc, output int n);
        n = 0;
        while (grant !== g && n < maxc) begin
            cyc();
            n++;
        end
        check_eq("grant_reached", {30'd0, grant}, {30'd0, g});
    endtask

    initial begin
        int n;
        int nf;
        logic [15:0] mask;

        // Reset and first frame
        run(3);
        check_eq("rst_an", {28'd0, an}, 32'hF);
        check_eq("rst_grant", {30'd0, grant}, 32'h0);
        check_eq("rst_frame", {31'd0, frame}, 32'h0);
        rst = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (frame !== 1'b1 && n < 40);
        check_eq("first_frame_cycles", n, 16);

        // Single request with leading-zero blanking
        req = 2'b01;
        data0 = 16'h0042;
        wait_grant(2'b01, 40, n);
        check_eq("single_latency_ok", {31'd0, n <= FR}, 1);
        cyc();
        check_eq("slot0_an", {28'd0, an}, 32'hE);
        check_eq("slot0_digit", {28'd0, digit}, 32'h2);
        run(4);
        check_eq("slot1_an", {28'd0, an}, 32'hD);
        check_eq("slot1_digit", {28'd0, digit}, 32'h4);
        run(4);
        check_eq("slot2_an", {28'd0, an}, 32'hF);
        run(4);
        check_eq("slot3_an", {28'd0, an}, 32'hF);

        // Tie with round-robin
        do_reset(2);
        req = 2'b11;
        wait_grant(2'b01, 40, n);
        req = 2'b00;
        wait_grant(2'b00, 40, n);
        req = 2'b11;
        wait_grant(2'b10, 40, n);

        // Hold then preemption
        do_reset(2);
        req = 2'b01;
        wait_grant(2'b01, 40, n);
        req = 2'b11;
        nf = 0;
        n = 0;
        while (grant !== 2'b10 && n < 100) begin
            cyc();
            n++;
            if (frame === 1'b1) nf++;
        end
        check_eq("preempt_frames", nf, 3);

        // Snapshot: mid-frame data change must not tear
        do_reset(2);
        data0 = 16'h1234;
        req = 2'b01;
        wait_grant(2'b01, 40, n);
        run(6);
        data0 = 16'h5678;
        run(7);
        check_eq("snap_old_digit", {28'd0, digit}, 32'h1);
        check_eq("snap_old_an", {28'd0, an}, 32'h7);
        run(4);
        check_eq("snap_new_digit", {28'd0, digit}, 32'h8);
        check_eq("snap_new_an", {28'd0, an}, 32'hE);

        // Reset during OWN1 at idx 2
        do_reset(2);
        data1 = 16'h0907;
        req = 2'b10;
        wait_grant(2'b10, 40, n);
        run(8);
        rst = 1'b1;
        cyc();
        check_eq("midrst_an", {28'd0, an}, 32'hF);
        check_eq("midrst_grant", {30'd0, grant}, 32'h0);
        rst = 1'b0;
        wait_grant(2'b10, 40, n);
        check_eq("midrst_regrant_latency", n, 16);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: mask = 16'hFFFF;
                    1: mask = 16'h0FFF;
                    2: mask = 16'h00FF;
                    default: mask = 16'h000F;
                endcase
                if ($urandom_range(0, 1) == 0) data0 = 16'($urandom) & mask;
                else data1 = 16'($urandom) & mask;
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
